// File: rtl/alu_pkg.sv
// Shared ALU types: op codes, flags and shifter control decode.
// Also holds the helper that splits barrel levels across pipe stages.
package alu_pkg;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_AND  = 5'd2,
        ALU_OR   = 5'd3,
        ALU_XOR  = 5'd4,
        ALU_SLT  = 5'd5,
        ALU_SLTU = 5'd6,
        ALU_SLL  = 5'd7,
        ALU_SRL  = 5'd8,
        ALU_SRA  = 5'd9,
        ALU_SLLW = 5'd10,
        ALU_SRLW = 5'd11,
        ALU_SRAW = 5'd12,
        ALU_ROL  = 5'd13,
        ALU_ROR  = 5'd14,
        ALU_RORW = 5'd15
    } alu_op_t;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic invalid_op;
    } alu_flags_t;

    typedef struct packed {
        logic dir;
        logic arith;
        logic rot;
        logic word;
        logic invalid;
    } shift_ctl_t;

    function automatic shift_ctl_t shift_decode(alu_op_t op);
        shift_ctl_t c;
        c = '0;
        unique case (op)
            ALU_SLL:  c.dir = 1'b1;
            ALU_SRL:  c.dir = 1'b0;
            ALU_SRA:  c.arith = 1'b1;
            ALU_SLLW: begin c.dir = 1'b1; c.word = 1'b1; end
            ALU_SRLW: c.word = 1'b1;
            ALU_SRAW: begin c.arith = 1'b1; c.word = 1'b1; end
            ALU_ROL:  begin c.dir = 1'b1; c.rot = 1'b1; end
            ALU_ROR:  c.rot = 1'b1;
            ALU_RORW: begin c.rot = 1'b1; c.word = 1'b1; end
            default:  c.invalid = 1'b1;
        endcase
        return c;
    endfunction

    // First barrel level owned by stage k; earlier stages absorb the remainder.
    function automatic int stage_lo(int k, int lvls, int stages);
        int base;
        int ext;
        base = lvls / stages;
        ext  = lvls % stages;
        return k * base + ((k < ext) ? k : ext);
    endfunction

endpackage

// File: rtl/alu_shifter_pipe_if.sv
// Issue/writeback handshake bundle for the pipelined shifter.
// master drives ops and consumes results; slave is the shifter.
interface alu_shifter_pipe_if
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int TAG_W = 6
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    alu_op_t          alu_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    alu_flags_t       flags;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, op_a, op_b, alu_op, in_tag, out_ready,
        input  in_ready, out_valid, result, flags, out_tag
    );

    modport slave (
        input  in_valid, op_a, op_b, alu_op, in_tag, out_ready,
        output in_ready, out_valid, result, flags, out_tag
    );
endinterface

// File: rtl/alu_shifter_pipe_stage.sv
// One pipe stage: barrel levels LO..HI as right shift/rotate plus its register.
// The last stage also un-reverses left ops and applies W sign extension.
module shift_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int LO    = 0,
    parameter int HI    = 0,
    parameter int TAG_W = 6,
    parameter bit LAST  = 1'b0,
    parameter int LVL   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush_i,
    input  logic             ld_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [LVL-1:0]   amt_i,
    input  shift_ctl_t       ctl_i,
    input  logic             fill_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic [LVL-1:0]   amt_o,
    output shift_ctl_t       ctl_o,
    output logic             fill_o,
    output logic [TAG_W-1:0] tag_o
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [LVL-1:0]   amt_q;
    shift_ctl_t       ctl_q;
    logic             fill_q;
    logic [TAG_W-1:0] tag_q;
    logic [WIDTH-1:0] shf;
    logic [WIDTH-1:0] rev;
    logic [WIDTH-1:0] fin;

    always_comb begin
        shf = data_i;
        for (int i = LO; i <= HI; i++) begin
            if (amt_i[i]) begin
                if (ctl_i.rot)
                    shf = (shf >> (1 << i)) | (shf << (WIDTH - (1 << i)));
                else
                    shf = (shf >> (1 << i)) |
                          (fill_i ? ~({WIDTH{1'b1}} >> (1 << i)) : '0);
            end
        end
    end

    always_comb begin
        rev = '0;
        for (int j = 0; j < WIDTH; j++)
            rev[j] = shf[WIDTH-1-j];
        fin = ctl_i.dir ? rev : shf;
        if (ctl_i.word)
            for (int j = 32; j < WIDTH; j++)
                fin[j] = fin[31];
        if (ctl_i.invalid)
            fin = '0;
        data_d = LAST ? fin : shf;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            amt_q   <= '0;
            ctl_q   <= '0;
            fill_q  <= 1'b0;
            tag_q   <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (ld_i) begin
            valid_q <= valid_i;
            if (valid_i) begin
                data_q <= data_d;
                amt_q  <= amt_i;
                ctl_q  <= ctl_i;
                fill_q <= fill_i;
                tag_q  <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign amt_o   = amt_q;
    assign ctl_o   = ctl_q;
    assign fill_o  = fill_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/alu_shifter_pipe.sv
// Pipelined shift/rotate unit: decode and operand prep, then STAGES barrel stages.
// Left ops enter bit-reversed so every stage only shifts or rotates right.
module alu_shifter_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int STAGES     = 2,
    parameter int TAG_W      = 6,
    parameter bit ENABLE_ROT = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    alu_shifter_pipe_if.slave   bus
);

    localparam int LVL = $clog2(WIDTH);
    localparam logic [LVL-1:0] WMASK = LVL'(31);

    logic [STAGES:0]   v;
    logic [WIDTH-1:0]  d   [STAGES+1];
    logic [LVL-1:0]    amt [STAGES+1];
    shift_ctl_t        c   [STAGES+1];
    logic [STAGES:0]   f;
    logic [TAG_W-1:0]  t   [STAGES+1];
    logic [STAGES-1:0] ld;

    shift_ctl_t        ctl_d;
    logic [LVL-1:0]    amt_d;
    logic [WIDTH-1:0]  ext;
    logic [WIDTH-1:0]  pre;
    logic              fill_d;
    alu_flags_t        fl;

    always_comb begin
        ctl_d = shift_decode(bus.alu_op);
        if (!ENABLE_ROT && ctl_d.rot) begin
            ctl_d.rot     = 1'b0;
            ctl_d.invalid = 1'b1;
        end
        if (WIDTH == 32)
            ctl_d.word = 1'b0;
        amt_d = bus.op_b[LVL-1:0];
        if (ctl_d.word)
            amt_d = amt_d & WMASK;
        // W ops: upper half becomes a copy (rotate), sign or zero.
        ext = bus.op_a;
        if (ctl_d.word)
            for (int j = 32; j < WIDTH; j++)
                ext[j] = ctl_d.rot ? bus.op_a[j-32]
                                   : (ctl_d.arith & bus.op_a[31]);
        fill_d = ctl_d.arith & ext[WIDTH-1];
        pre = ext;
        if (ctl_d.dir)
            for (int j = 0; j < WIDTH; j++)
                pre[j] = ext[WIDTH-1-j];
    end

    // A stage may load when any later stage has a hole or the output drains.
    always_comb begin
        ld = '0;
        for (int k = 0; k < STAGES; k++) begin
            ld[k] = bus.out_ready;
            for (int j = k + 1; j <= STAGES; j++)
                if (!v[j])
                    ld[k] = 1'b1;
        end
    end

    assign v[0]   = bus.in_valid;
    assign d[0]   = pre;
    assign amt[0] = amt_d;
    assign c[0]   = ctl_d;
    assign f[0]   = fill_d;
    assign t[0]   = bus.in_tag;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        shift_stage #(
            .WIDTH (WIDTH),
            .LO    (stage_lo(k, LVL, STAGES)),
            .HI    (stage_lo(k + 1, LVL, STAGES) - 1),
            .TAG_W (TAG_W),
            .LAST  (k == STAGES - 1)
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .flush_i (flush),
            .ld_i    (ld[k]),
            .valid_i (v[k]),
            .data_i  (d[k]),
            .amt_i   (amt[k]),
            .ctl_i   (c[k]),
            .fill_i  (f[k]),
            .tag_i   (t[k]),
            .valid_o (v[k+1]),
            .data_o  (d[k+1]),
            .amt_o   (amt[k+1]),
            .ctl_o   (c[k+1]),
            .fill_o  (f[k+1]),
            .tag_o   (t[k+1])
        );
    end

    always_comb begin
        fl = '0;
        fl.invalid_op = c[STAGES].invalid;
    end

    assign bus.in_ready  = ld[0] & ~flush;
    assign bus.out_valid = v[STAGES];
    assign bus.result    = d[STAGES];
    assign bus.flags     = fl;
    assign bus.out_tag   = t[STAGES];

endmodule

// File: tb/tb_alu_shifter_pipe.sv
// Scoreboard bench for alu_shifter_pipe (WIDTH=64, STAGES=2).
// Expected results come from a behavioural shift model at issue time.
module tb_alu_shifter_pipe;
    import alu_pkg::*;

    typedef struct {
        logic [63:0] r;
        logic        inv;
        logic [5:0]  tag;
    } exp_t;

    logic clk;
    logic rst;
    logic flush;

    alu_shifter_pipe_if #(.WIDTH(64), .TAG_W(6)) bus ();

    alu_shifter_pipe #(
        .WIDTH(64), .STAGES(2), .TAG_W(6), .ENABLE_ROT(1'b1)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    exp_t        q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          n_out   = 0;
    logic        stall   = 1'b0;
    logic        pflush  = 1'b0;
    logic [63:0] h_res;
    logic [5:0]  h_tag;
    alu_flags_t  h_fl;
    logic        done;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(alu_op_t op, logic [63:0] a,
                                   logic [63:0] b, logic [5:0] tag);
        exp_t        e;
        logic [5:0]  s;
        logic [4:0]  sw;
        logic [31:0] w;
        logic [31:0] a32;
        s = b[5:0];
        sw = b[4:0];
        a32 = a[31:0];
        w = '0;
        e.r = '0;
        e.inv = 1'b0;
        e.tag = tag;
        case (op)
            ALU_SLL: e.r = a << s;
            ALU_SRL: e.r = a >> s;
            ALU_SRA: e.r = $signed(a) >>> s;
            ALU_ROL: e.r = (s == 0) ? a : ((a << s) | (a >> (7'd64 - s)));
            ALU_ROR: e.r = (s == 0) ? a : ((a >> s) | (a << (7'd64 - s)));
            ALU_SLLW: begin w = a32 << sw; e.r = {{32{w[31]}}, w}; end
            ALU_SRLW: begin w = a32 >> sw; e.r = {{32{w[31]}}, w}; end
            ALU_SRAW: begin
                w = $signed(a32) >>> sw;
                e.r = {{32{w[31]}}, w};
            end
            ALU_RORW: begin
                w = (sw == 0) ? a32 : ((a32 >> sw) | (a32 << (6'd32 - sw)));
                e.r = {{32{w[31]}}, w};
            end
            default: e.inv = 1'b1;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t       e;
        alu_flags_t ef;
        if (rst) begin
            q.delete();
            stall  = 1'b0;
            pflush = 1'b0;
        end else begin
            if (stall && !pflush) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_result", bus.result, h_res);
                check("hold_tag", 64'(bus.out_tag), 64'(h_tag));
                check("hold_flags", 64'(bus.flags), 64'(h_fl));
            end
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                check("sb_nonempty", 64'(q.size() != 0), 64'd1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    ef = '0;
                    ef.invalid_op = e.inv;
                    check("tag", 64'(bus.out_tag), 64'(e.tag));
                    check("result", bus.result, e.r);
                    check("flags", 64'(bus.flags), 64'(ef));
                end
            end
            stall  = bus.out_valid && !bus.out_ready;
            h_res  = bus.result;
            h_tag  = bus.out_tag;
            h_fl   = bus.flags;
            pflush = flush;
            if (flush)
                q.delete();
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send(input alu_op_t op, input logic [63:0] a,
                        input logic [63:0] b, input logic [5:0] tag);
        logic acc;
        acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.alu_op = op;
        bus.op_a = a;
        bus.op_b = b;
        bus.in_tag = tag;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc = 1'b1;
                q.push_back(model(op, a, b, tag));
            end
            @(posedge clk);
            #1;
        end
        check("send_accepted", 64'(acc), 64'd1);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && q.size() != 0; n++)
            @(posedge clk);
        #1;
        check("drain", 64'(q.size()), 64'd0);
    endtask

    alu_op_t     d_op [9] = '{ALU_SRAW, ALU_SRA, ALU_ROR, ALU_RORW, ALU_ROL,
                              ALU_SLLW, ALU_SRL, ALU_SRLW, ALU_ADD};
    logic [63:0] d_a  [9] = '{64'h0000_0000_8000_0000, 64'h8000_0000_0000_0000,
                              64'h1, 64'h1, 64'h8000_0000_0000_0001,
                              64'hFFFF_FFFF_8000_0001, 64'h1234_5678_9ABC_DEF0,
                              64'h0000_0000_F000_0000, 64'hDEAD_BEEF_0000_0001};
    logic [63:0] d_b  [9] = '{64'd4, 64'h41, 64'd1, 64'd1, 64'd4, 64'd1,
                              64'h40, 64'd28, 64'd3};
    alu_op_t     r_op [11] = '{ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLLW, ALU_SRLW,
                              ALU_SRAW, ALU_ROL, ALU_ROR, ALU_RORW, ALU_ADD,
                              ALU_XOR};

    initial begin
        int cnt;
        int n0;
        rst = 1'b1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.alu_op = ALU_SLL;
        bus.in_tag = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_result", bus.result, 64'd0);
        check("rst_flags", 64'(bus.flags), 64'd0);
        check("rst_out_tag", 64'(bus.out_tag), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;

        send(ALU_SLL, 64'd1, 64'd63, 6'd1);
        idle();
        cnt = 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.out_valid) break;
            @(posedge clk);
            cnt++;
        end
        check("latency", 64'(cnt), 64'd2);
        @(posedge clk);
        #1;
        drain();

        for (int i = 0; i < 9; i++)
            send(d_op[i], d_a[i], d_b[i], (i == 8) ? 6'd5 : 6'(30 + i));
        idle();
        drain();

        n0 = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(r_op[i], 64'hF0F0_1234_8765_0FF1 + 64'(i), 64'(i * 9),
                         6'(20 + i));
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", 64'(n_out - n0), 64'd8);

        bus.out_ready = 1'b0;
        send(ALU_SRL, 64'hAAAA, 64'd1, 6'd10);
        send(ALU_SLL, 64'h5555, 64'd2, 6'd11);
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.alu_op = ALU_ROR;
        bus.op_a = 64'h77;
        bus.op_b = 64'd3;
        bus.in_tag = 6'd12;
        @(negedge clk);
        check("flush_in_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        #1 flush = 1'b0;
        idle();
        @(negedge clk);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        n0 = n_out;
        repeat (8) @(posedge clk);
        #1;
        check("flush_no_output", 64'(n_out - n0), 64'd0);

        bus.out_ready = 1'b0;
        send(ALU_SRA, 64'hFFFF_0000_0000_0000, 64'd8, 6'd40);
        send(ALU_ROL, 64'h3, 64'd62, 6'd41);
        rst = 1'b1;
        idle();
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("mid_rst_result", bus.result, 64'd0);
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        n0 = n_out;
        repeat (6) @(posedge clk);
        #1;
        check("rst_no_output", 64'(n_out - n0), 64'd0);

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send(r_op[$urandom_range(0, 10)], {$urandom, $urandom},
                         {$urandom, $urandom}, 6'($urandom));
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 bus.out_ready = ($urandom_range(0, 3) != 0);
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
